receptor: RTL and testbench

RECEPTOR -- requirements
Module: receptor

---
 rtl/receptor.sv | 188 ++++++++++++++++++
 tb/tb_receptor.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/receptor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : receptor                                                      |
// | Purpose  : Snooping side of a MESI cache-line controller. Decodes a pair |
// |            of remote bus messages each cycle, updates the local MESI     |
// |            state, signals sharing, and runs a write-back wait when a     |
// |            modified line is snooped.                                     |
// | Ports    : CLK      - clock, rising edge active                          |
// |            CLR      - asynchronous active-low reset                      |
// |            BUS[5:0] - snooped message pair {hi[5:3], lo[2:0]}            |
// |            LD       - one-cycle load strobe for LD_state                 |
// |            LD_state - MESI value to load (001 I,010 S,011 E,100 M)       |
// |            WB_ack   - memory accepted the write-back                     |
// |            state    - registered MESI state                              |
// |            SH       - one-cycle pulse: valid copy held on remote read    |
// |            WB_req   - write-back requested (level)                       |
// |            ABORT    - abort remote memory access, equals WB_req          |
// |            BUSY     - write-back wait in progress                        |
// |            ERR      - one-cycle pulse: illegal code/load/protocol        |
// | Options  : RECEPTOR_WB_TIMEOUT_EN - give up the write-back wait after    |
// |            16 cycles without WB_ack (exit to target, pulse ERR).         |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module receptor (
  input  logic       CLK,
  input  logic       CLR,
  input  logic [5:0] BUS,
  input  logic       LD,
  input  logic [2:0] LD_state,
  input  logic       WB_ack,
  output logic [2:0] state,
  output logic       SH,
  output logic       WB_req,
  output logic       ABORT,
  output logic       BUSY,
  output logic       ERR
);

  localparam logic [2:0] MESI_I = 3'b001;
  localparam logic [2:0] MESI_S = 3'b010;
  localparam logic [2:0] MESI_E = 3'b011;
  localparam logic [2:0] MESI_M = 3'b100;

  localparam logic [2:0] MSG_RD_MISS = 3'b001;
  localparam logic [2:0] MSG_WR_MISS = 3'b010;
  localparam logic [2:0] MSG_INVAL   = 3'b100;

  typedef enum logic [0:0] {
    PH_IDLE = 1'b0,
    PH_WAIT = 1'b1
  } phase_t;

  phase_t     phase, phase_nx;
  logic [2:0] mesi, mesi_nx;
  logic [2:0] target, target_nx;
  logic       sh_q, sh_nx;
  logic       err_q, err_nx;

  logic [2:0] hi, lo;
  logic       illegal, has_wr_miss, has_inval, has_rd_miss;
  logic       wr, rd, ld_valid;

`ifdef RECEPTOR_WB_TIMEOUT_EN
  logic [3:0] tmo_cnt, tmo_cnt_nx;
`endif

  assign hi = BUS[5:3];
  assign lo = BUS[2:0];

  // Codes above 100 are undefined; one bad field poisons the whole cycle.
  assign illegal     = (hi > MSG_INVAL) || (lo > MSG_INVAL);
  assign has_wr_miss = (hi == MSG_WR_MISS) || (lo == MSG_WR_MISS);
  assign has_inval   = (hi == MSG_INVAL) || (lo == MSG_INVAL);
  assign has_rd_miss = (hi == MSG_RD_MISS) || (lo == MSG_RD_MISS);
  assign wr          = has_wr_miss || has_inval;
  assign rd          = has_rd_miss && !wr;
  assign ld_valid    = (LD_state >= MESI_I) && (LD_state <= MESI_M);

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      phase  <= PH_IDLE;
      mesi   <= MESI_I;
      target <= 3'b000;
      sh_q   <= 1'b0;
      err_q  <= 1'b0;
`ifdef RECEPTOR_WB_TIMEOUT_EN
      tmo_cnt <= 4'd0;
`endif
    end else begin
      phase  <= phase_nx;
      mesi   <= mesi_nx;
      target <= target_nx;
      sh_q   <= sh_nx;
      err_q  <= err_nx;
`ifdef RECEPTOR_WB_TIMEOUT_EN
      tmo_cnt <= tmo_cnt_nx;
`endif
    end
  end

  always_comb begin
    phase_nx  = phase;
    mesi_nx   = mesi;
    target_nx = target;
    sh_nx     = 1'b0;
    err_nx    = 1'b0;
`ifdef RECEPTOR_WB_TIMEOUT_EN
    tmo_cnt_nx = tmo_cnt;
`endif
    if (phase == PH_WAIT) begin
      // Bus and load traffic are deliberately deaf while the line is parked.
      if (WB_ack) begin
        phase_nx = PH_IDLE;
        mesi_nx  = target;
`ifdef RECEPTOR_WB_TIMEOUT_EN
      end else if (tmo_cnt == 4'd15) begin
        // Sixteenth unacknowledged wait cycle: give up the write-back.
        phase_nx   = PH_IDLE;
        mesi_nx    = target;
        err_nx     = 1'b1;
        tmo_cnt_nx = 4'd0;
      end else begin
        tmo_cnt_nx = tmo_cnt + 4'd1;
`endif
      end
    end else if (LD) begin
      // A local load wins; any coincident bus message is simply dropped.
      if (ld_valid) begin
        mesi_nx = LD_state;
      end else begin
        err_nx = 1'b1;
      end
    end else if (illegal) begin
      err_nx = 1'b1;
    end else begin
      case (mesi)
        MESI_S: begin
          if (rd) begin
            sh_nx = 1'b1;
          end else if (wr) begin
            mesi_nx = MESI_I;
          end
        end
        MESI_E: begin
          if (rd) begin
            mesi_nx = MESI_S;
            sh_nx   = 1'b1;
          end else if (wr) begin
            mesi_nx = MESI_I;
          end
        end
        MESI_M: begin
          if (has_wr_miss) begin
            phase_nx  = PH_WAIT;
            target_nx = MESI_I;
`ifdef RECEPTOR_WB_TIMEOUT_EN
            tmo_cnt_nx = 4'd0;
`endif
          end else if (has_inval) begin
            // An invalidate hitting a dirty line means someone else wrote
            // without a miss: drop the copy and flag the protocol breach.
            mesi_nx = MESI_I;
            err_nx  = 1'b1;
          end else if (rd) begin
            phase_nx  = PH_WAIT;
            target_nx = MESI_S;
            sh_nx     = 1'b1;
`ifdef RECEPTOR_WB_TIMEOUT_EN
            tmo_cnt_nx = 4'd0;
`endif
          end
        end
        default: begin
          // Invalid line: nothing to snoop.
        end
      endcase
    end
  end

  assign state  = mesi;
  assign SH     = sh_q;
  assign ERR    = err_q;
  assign BUSY   = (phase == PH_WAIT);
  assign WB_req = BUSY;
  assign ABORT  = BUSY;

endmodule
`default_nettype wire

// File: tb/tb_receptor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_receptor                                                   |
// | Purpose  : Self-checking bench for receptor: vector table, hand-written  |
// |            wait/timeout/reset sequences, and randomized traffic checked  |
// |            against a behavioural model.                                  |
// | Options  : RECEPTOR_WB_TIMEOUT_EN selects timeout expectations.          |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_receptor;

  logic       clk;
  logic       clr_n;
  logic [5:0] bus;
  logic       ld;
  logic [2:0] ld_state;
  logic       wb_ack;
  logic [2:0] state;
  logic       sh, wb_req, abort, busy, err;

  int checks   = 0;
  int failures = 0;

  receptor dut (
    .CLK      (clk),
    .CLR      (clr_n),
    .BUS      (bus),
    .LD       (ld),
    .LD_state (ld_state),
    .WB_ack   (wb_ack),
    .state    (state),
    .SH       (sh),
    .WB_req   (wb_req),
    .ABORT    (abort),
    .BUSY     (busy),
    .ERR      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       ld;
    logic [2:0] lds;
    logic [5:0] bus;
    logic       ack;
    logic [2:0] e_state;
    logic       e_sh;
    logic       e_busy;
    logic       e_err;
    string      name;
  } vec_t;

  vec_t vecs[$];

  // ---------------- behavioural model ----------------
  logic [2:0] m_state, m_tgt;
  bit         m_wait, m_sh, m_err;
  int         m_unacked;

  function automatic logic [7:0] dut_out();
    return {state, sh, wb_req, abort, busy, err};
  endfunction

  function automatic logic [7:0] model_out();
    return {m_state, m_sh, m_wait, m_wait, m_wait, m_err};
  endfunction

  task automatic model_reset();
    m_state = 3'd1; m_tgt = 3'd0; m_wait = 0; m_sh = 0; m_err = 0; m_unacked = 0;
  endtask

  task automatic model_step(input bit l, input logic [2:0] lv, input logic [5:0] b, input bit a);
    logic [2:0] f [2];
    bit bad, wm, inv, rdm, wr, rd;
    m_sh = 0;
    m_err = 0;
    if (m_wait) begin
      if (a) begin
        m_wait = 0;
        m_state = m_tgt;
      end else begin
        m_unacked++;
`ifdef RECEPTOR_WB_TIMEOUT_EN
        if (m_unacked == 16) begin
          m_wait = 0;
          m_state = m_tgt;
          m_err = 1;
        end
`endif
      end
      return;
    end
    if (l) begin
      if (lv >= 3'd1 && lv <= 3'd4) m_state = lv;
      else m_err = 1;
      return;
    end
    f[0] = b[5:3];
    f[1] = b[2:0];
    bad = 0; wm = 0; inv = 0; rdm = 0;
    for (int i = 0; i < 2; i++) begin
      if (f[i] > 3'd4) bad = 1;
      if (f[i] == 3'd2) wm = 1;
      if (f[i] == 3'd4) inv = 1;
      if (f[i] == 3'd1) rdm = 1;
    end
    if (bad) begin
      m_err = 1;
      return;
    end
    wr = wm | inv;
    rd = rdm & ~wr;
    case (m_state)
      3'd2: if (wr) m_state = 3'd1; else if (rd) m_sh = 1;
      3'd3: if (wr) m_state = 3'd1; else if (rd) begin m_state = 3'd2; m_sh = 1; end
      3'd4: begin
        if (wm) begin
          m_wait = 1; m_tgt = 3'd1; m_unacked = 0;
        end else if (inv) begin
          m_state = 3'd1; m_err = 1;
        end else if (rd) begin
          m_wait = 1; m_tgt = 3'd2; m_unacked = 0; m_sh = 1;
        end
      end
      default: ;
    endcase
  endtask

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got {state,SH,WB_req,ABORT,BUSY,ERR}=%b expected=%b", name, act, exp);
    end
  endtask

  task automatic step(input bit l, input logic [2:0] lv, input logic [5:0] b, input bit a);
    ld = l; ld_state = lv; bus = b; wb_ack = a;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input logic [2:0] s, input bit h, input bit bz, input bit e);
    chk(name, dut_out(), {s, h, bz, bz, bz, e});
  endtask

  task automatic do_reset();
    clr_n = 1'b0;
    ld = 0; ld_state = 3'd0; bus = 6'd0; wb_ack = 0;
    @(posedge clk);
    #1;
    chk("reset_state", dut_out(), 8'b001_0_0_0_0_0);
    clr_n = 1'b1;
    model_reset();
  endtask

  int held;

  initial begin
    clr_n = 1'b0;
    ld = 0; ld_state = 3'd0; bus = 6'd0; wb_ack = 0;

    //            ld  lds     bus        ack  state   sh busy err
    vecs.push_back(vec_t'{1, 3'b011, 6'b000000, 0, 3'b011, 0, 0, 0, "ld_E"});
    vecs.push_back(vec_t'{0, 3'b000, 6'b000001, 0, 3'b010, 1, 0, 0, "E_rd_to_S"});
    vecs.push_back(vec_t'{0, 3'b000, 6'b000000, 0, 3'b010, 0, 0, 0, "sh_one_cycle"});
    vecs.push_back(vec_t'{0, 3'b000, 6'b000001, 0, 3'b010, 1, 0, 0, "S_rd_stay"});
    vecs.push_back(vec_t'{0, 3'b000, 6'b010100, 0, 3'b001, 0, 0, 0, "S_wr_to_I"});
    vecs.push_back(vec_t'{0, 3'b000, 6'b000001, 1, 3'b001, 0, 0, 0, "I_rd_ack_ignored"});
    vecs.push_back(vec_t'{0, 3'b000, 6'b000111, 0, 3'b001, 0, 0, 1, "I_illegal"});
    vecs.push_back(vec_t'{1, 3'b011, 6'b000010, 0, 3'b011, 0, 0, 0, "ld_drops_bus"});
    vecs.push_back(vec_t'{1, 3'b111, 6'b000000, 0, 3'b011, 0, 0, 1, "ld_illegal"});
    vecs.push_back(vec_t'{0, 3'b000, 6'b011011, 0, 3'b011, 0, 0, 0, "E_writeback_noop"});
    vecs.push_back(vec_t'{0, 3'b000, 6'b000100, 0, 3'b001, 0, 0, 0, "E_inval_to_I"});
    vecs.push_back(vec_t'{1, 3'b100, 6'b000000, 0, 3'b100, 0, 0, 0, "ld_M"});
    vecs.push_back(vec_t'{0, 3'b000, 6'b000111, 0, 3'b100, 0, 0, 1, "M_illegal"});
    vecs.push_back(vec_t'{0, 3'b000, 6'b000100, 0, 3'b001, 0, 0, 1, "M_inval_only"});
    vecs.push_back(vec_t'{1, 3'b010, 6'b000000, 0, 3'b010, 0, 0, 0, "ld_S"});
    vecs.push_back(vec_t'{0, 3'b000, 6'b001010, 0, 3'b001, 0, 0, 0, "S_wrmiss_beats_rd"});
    vecs.push_back(vec_t'{1, 3'b011, 6'b000000, 0, 3'b011, 0, 0, 0, "ld_E_again"});
    vecs.push_back(vec_t'{0, 3'b000, 6'b101001, 0, 3'b011, 0, 0, 1, "E_illegal_hi"});
    vecs.push_back(vec_t'{0, 3'b000, 6'b001000, 0, 3'b010, 1, 0, 0, "E_rd_hi"});

    do_reset();
    foreach (vecs[i]) begin
      step(vecs[i].ld, vecs[i].lds, vecs[i].bus, vecs[i].ack);
      expect_out(vecs[i].name, vecs[i].e_state, vecs[i].e_sh, vecs[i].e_busy, vecs[i].e_err);
    end

    // Read miss on M: wait target S, ack on third wait edge.
    step(1, 3'b100, 6'd0, 0);
    step(0, 3'b000, 6'b000001, 0);
    expect_out("M_rd_enter_wait", 3'b100, 1, 1, 0);
    step(0, 3'b000, 6'b000010, 0);
    expect_out("wait_bus_ignored", 3'b100, 0, 1, 0);
    step(1, 3'b001, 6'b000111, 0);
    expect_out("wait_ld_illegal_ignored", 3'b100, 0, 1, 0);
    step(0, 3'b000, 6'b000000, 1);
    expect_out("wait_ack_to_S", 3'b010, 0, 0, 0);
    step(0, 3'b000, 6'b000000, 1);
    expect_out("idle_ack_ignored", 3'b010, 0, 0, 0);

    // Write miss on M with no acknowledge.
    step(1, 3'b100, 6'd0, 0);
    step(0, 3'b000, 6'b001010, 0);
    expect_out("M_wrmiss_enter_wait", 3'b100, 0, 1, 0);
`ifdef RECEPTOR_WB_TIMEOUT_EN
    held = 0;
    for (int i = 0; i < 15; i++) begin
      step(0, 3'b000, 6'd0, 0);
      if (busy && state == 3'b100 && !err) held++;
    end
    chk("timeout_hold_15", {4'd0, held[3:0]}, 8'd15);
    step(0, 3'b000, 6'd0, 0);
    expect_out("timeout_exit", 3'b001, 0, 0, 1);
    step(0, 3'b000, 6'd0, 0);
    expect_out("timeout_err_pulse", 3'b001, 0, 0, 0);
`else
    held = 0;
    for (int i = 0; i < 45; i++) begin
      step(0, 3'b000, 6'd0, 0);
      if (busy && wb_req && abort && state == 3'b100 && !err) held++;
    end
    chk("no_timeout_hold_45", held[7:0], 8'd45);
    step(0, 3'b000, 6'd0, 1);
    expect_out("late_ack_to_I", 3'b001, 0, 0, 0);
`endif

    // Reset asserted mid-wait abandons the write-back.
    step(1, 3'b100, 6'd0, 0);
    step(0, 3'b000, 6'b000001, 0);
    step(0, 3'b000, 6'd0, 0);
    step(0, 3'b000, 6'd0, 0);
    expect_out("pre_clr_wait", 3'b100, 0, 1, 0);
    clr_n = 1'b0;
    #1;
    expect_out("clr_async_mid_wait", 3'b001, 0, 0, 0);
    @(posedge clk);
    #1;
    clr_n = 1'b1;
    step(0, 3'b000, 6'd0, 1);
    expect_out("after_clr_idle_I", 3'b001, 0, 0, 0);

    // Randomized traffic against the model.
    do_reset();
    for (int n = 0; n < 2000; n++) begin
      bit         rl, ra;
      logic [2:0] rlv;
      logic [5:0] rb;
      int         r;
      rl  = ($urandom_range(0, 7) == 0);
      rlv = 3'($urandom_range(0, 7));
      // Bias loads toward M so the wait path gets exercised.
      if ($urandom_range(0, 2) == 0) rlv = 3'b100;
      for (int k = 0; k < 2; k++) begin
        r = $urandom_range(0, 19);
        if (r < 18 || rl) rb[k*3 +: 3] = 3'(r % 5);
        else rb[k*3 +: 3] = 3'(5 + r % 3);
      end
      ra = ($urandom_range(0, 3) == 0);
      step(rl, rlv, rb, ra);
      model_step(rl, rlv, rb, ra);
      chk($sformatf("rand_%0d", n), dut_out(), model_out());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
